// File: rtl/controller_interface.sv
// Polls two 8-button serial pads and publishes their states as CPU-readable bytes at 0x7002/0x7003.
// Define CONTROLLER_INTERFACE_DEBOUNCE_EN to require two agreeing polls before a visible bit changes.
module controller_interface #(
  parameter int CLK_DIV = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_start,
  input  logic       SELECT_controller,
  input  logic       address,
  input  logic       read,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  input  logic [1:0] ctrl_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // The latch phase spans 2D cycles, so the divider is wide enough for 2*255-1.
  localparam logic [8:0] LAST_PHASE = 9'(CLK_DIV - 1);
  localparam logic [8:0] LAST_LATCH = 9'(2 * CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [8:0] div_q, div_d;
  logic [2:0] bitn_q, bitn_d;
  logic [7:0] shift0_q, shift1_q;
  logic [7:0] vis0_q, vis1_q;
  logic       ctrl_latch_q, ctrl_clk_q, busy_q;
  logic       sample_s, commit_s;

`ifdef CONTROLLER_INTERFACE_DEBOUNCE_EN
  logic [7:0] prev0_q, prev1_q;

  function automatic logic [7:0] debounce_merge(input logic [7:0] vis,
                                                input logic [7:0] prev,
                                                input logic [7:0] smp);
    logic [7:0] agree;
    agree = ~(smp ^ prev);
    return (vis & ~agree) | (smp & agree);
  endfunction
`endif

  // Next-state logic for the poll sequencer, divider and bit counter.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q + 9'd1;
    bitn_d   = bitn_q;
    sample_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d = 9'd0;
        if (poll_start) begin
          state_d = ST_LATCH;
          bitn_d  = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (div_q == LAST_LATCH) begin
          state_d = ST_LOW;
          div_d   = 9'd0;
        end else begin
          state_d = ST_LATCH;
        end
      end
      ST_LOW: begin
        if (div_q == LAST_PHASE) begin
          sample_s = 1'b1;
          div_d    = 9'd0;
          if (bitn_q == 3'd7) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_HIGH;
          end
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (div_q == LAST_PHASE) begin
          state_d = ST_LOW;
          div_d   = 9'd0;
          bitn_d  = bitn_q + 3'd1;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_COMMIT: begin
        state_d  = ST_IDLE;
        div_d    = 9'd0;
        commit_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = 9'd0;
        bitn_d  = 3'd0;
      end
    endcase
  end

  // Sequencer state and pad-facing outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= 9'd0;
      bitn_q       <= 3'd0;
      ctrl_latch_q <= 1'b0;
      ctrl_clk_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bitn_q       <= bitn_d;
      ctrl_latch_q <= (state_d == ST_LATCH);
      ctrl_clk_q   <= (state_d == ST_HIGH);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Deserialise both pads; pads are active-low, stored as 1 = pressed, first bit ends up in bit 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift0_q <= 8'h00;
      shift1_q <= 8'h00;
    end else if (sample_s) begin
      shift0_q <= {shift0_q[6:0], ~ctrl_data[0]};
      shift1_q <= {shift1_q[6:0], ~ctrl_data[1]};
    end else begin
      shift0_q <= shift0_q;
      shift1_q <= shift1_q;
    end
  end

`ifdef CONTROLLER_INTERFACE_DEBOUNCE_EN
  // Visible bytes change only where two consecutive polls agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      vis0_q  <= 8'h00;
      vis1_q  <= 8'h00;
      prev0_q <= 8'h00;
      prev1_q <= 8'h00;
    end else if (commit_s) begin
      vis0_q  <= debounce_merge(vis0_q, prev0_q, shift0_q);
      vis1_q  <= debounce_merge(vis1_q, prev1_q, shift1_q);
      prev0_q <= shift0_q;
      prev1_q <= shift1_q;
    end else begin
      vis0_q  <= vis0_q;
      vis1_q  <= vis1_q;
      prev0_q <= prev0_q;
      prev1_q <= prev1_q;
    end
  end
`else
  // Both visible bytes load together so the CPU never sees a half-shifted pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      vis0_q <= 8'h00;
      vis1_q <= 8'h00;
    end else if (commit_s) begin
      vis0_q <= shift0_q;
      vis1_q <= shift1_q;
    end else begin
      vis0_q <= vis0_q;
      vis1_q <= vis1_q;
    end
  end
`endif

  // Zero-wait-state CPU read mux.
  always_comb begin
    data_out_en = SELECT_controller & read;
    data_out    = 8'h00;
    if (data_out_en) begin
      data_out = address ? vis1_q : vis0_q;
    end else begin
      data_out = 8'h00;
    end
  end

  assign ctrl_latch = ctrl_latch_q;
  assign ctrl_clk   = ctrl_clk_q;
  assign busy       = busy_q;

endmodule
